// File: rtl/spi_master_shift.sv
// SPI master shift engine: frames one DATA_W-bit full-duplex transfer per start,
// advancing SCLK one half-period per edge of the divider output div_clk.
module spi_master_shift #(
  parameter int unsigned DATA_W = 8,
  parameter bit          CPOL   = 1'b0,
  parameter bit          CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_clk,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int unsigned       HP_W    = $clog2(2 * DATA_W) + 1;
  localparam logic [HP_W-1:0]   HP_LAST = HP_W'(2 * DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]        state;
  logic              div_q;
  logic              tick;
  logic              leading;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [HP_W-1:0]   hp;

  // div_clk is a register in this clock domain, so any change is one half-period tick.
  assign tick    = div_clk ^ div_q;
  assign leading = ~hp[0];

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see updated shifters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      div_q   <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      hp      <= '0;
      sclk    <= CPOL;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      div_q <= div_clk;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SETUP;
            busy  <= 1'b1;
            cs_n  <= 1'b0;
            tx_sr <= tx_data;
            rx_sr <= '0;
            hp    <= '0;
            if (!CPHA) mosi <= tx_data[DATA_W-1];
          end
        end
        S_SETUP: begin
          if (tick) state <= S_XFER;
        end
        S_XFER: begin
          if (tick) begin
            sclk <= ~sclk;
            hp   <= hp + 1'b1;
            if (!CPHA) begin
              // Mode with data valid before the first edge: sample leading, shift trailing.
              if (leading) begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
              end else if (hp != HP_LAST) begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                mosi  <= tx_sr[DATA_W-2];
              end
            end else begin
              if (leading) begin
                mosi  <= tx_sr[DATA_W-1];
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
              end else begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
              end
            end
            if (hp == HP_LAST) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // One half-period of CS hold after the final SCLK edge.
          if (tick) begin
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sr;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shift.sv
// Bench for spi_master_shift: a mode-0 and a mode-3 instance share a D=6 divider model,
// checked against a protocol-level SPI slave model and loopback/tied MISO patterns.
module tb_spi_master_shift;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic div_clk;
  bit   div_stall;
  int   div_cnt;

  logic         start_a, start_b;
  logic [W-1:0] tx_a, tx_b;
  logic         busy_a, done_a, sclk_a, mosi_a, miso_a, cs_a;
  logic         busy_b, done_b, sclk_b, mosi_b, miso_b, cs_b;
  logic [W-1:0] rx_a, rx_b;

  int checks   = 0;
  int failures = 0;

  // Slave model state (index 0: mode 0 instance, index 1: CPOL=1/CPHA=1 instance).
  int           miso_mode [2];  // 0 slave word, 1 loopback, 2 tied high
  logic         slv_miso  [2];
  logic [W-1:0] slv_word  [2];
  logic [W-1:0] slv_cap   [2];
  int           slv_sent  [2];
  logic         prev_sclk [2] = '{1'b0, 1'b1};
  logic         prev_cs   [2] = '{1'b1, 1'b1};
  logic         sclk_v [2], cs_v [2], mosi_v [2];
  bit           inst1, edge_v, lead_v, trail_v;

  // Waveform statistics for instance A and B.
  int   cyc = 0, last_rise = 0, rise_cnt = 0, per_bad = 0, hi_bad = 0;
  bit   have_rise = 0;
  int   done_tot = 0, done_wide = 0, sclk_chg = 0, mosi_bad = 0;
  logic prev_done = 1'b0, prev_mosi_b = 1'b0;

  assign sclk_v[0] = sclk_a;  assign sclk_v[1] = sclk_b;
  assign cs_v[0]   = cs_a;    assign cs_v[1]   = cs_b;
  assign mosi_v[0] = mosi_a;  assign mosi_v[1] = mosi_b;

  assign miso_a = (miso_mode[0] == 1) ? mosi_a : (miso_mode[0] == 2) ? 1'b1 : slv_miso[0];
  assign miso_b = (miso_mode[1] == 1) ? mosi_b : (miso_mode[1] == 2) ? 1'b1 : slv_miso[1];

  spi_master_shift #(.DATA_W(W), .CPOL(1'b0), .CPHA(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .div_clk(div_clk), .start(start_a), .tx_data(tx_a),
    .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a),
    .miso(miso_a), .cs_n(cs_a)
  );

  spi_master_shift #(.DATA_W(W), .CPOL(1'b1), .CPHA(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .div_clk(div_clk), .start(start_b), .tx_data(tx_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b),
    .miso(miso_b), .cs_n(cs_b)
  );

  initial forever #5 clk = ~clk;

  // Divider with D = 6: div_clk toggles every 3 clk cycles unless stalled.
  initial begin
    div_clk = 1'b0;
    div_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!div_stall) begin
        div_cnt++;
        if (div_cnt == 3) begin
          div_cnt = 0;
          div_clk = ~div_clk;
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!cs_a && prev_cs[0]) begin
      rise_cnt  = 0;
      have_rise = 0;
      per_bad   = 0;
      hi_bad    = 0;
    end
    if (!cs_a && !prev_sclk[0] && sclk_a) begin
      rise_cnt++;
      if (have_rise && (cyc - last_rise != 6)) per_bad++;
      last_rise = cyc;
      have_rise = 1;
    end
    if (!cs_a && prev_sclk[0] && !sclk_a && (cyc - last_rise != 3)) hi_bad++;
    if (sclk_a != prev_sclk[0]) sclk_chg++;
    if (done_a) done_tot++;
    if (done_a && prev_done) done_wide++;
    prev_done = done_a;
    if (!rst && (mosi_b != prev_mosi_b) && !(prev_sclk[1] && !sclk_b)) mosi_bad++;
    prev_mosi_b = mosi_b;

    for (int i = 0; i < 2; i++) begin
      inst1   = (i == 1);
      edge_v  = (prev_sclk[i] != sclk_v[i]);
      lead_v  = edge_v && (prev_sclk[i] == inst1);
      trail_v = edge_v && (sclk_v[i] == inst1);
      if (prev_cs[i] && !cs_v[i]) begin
        slv_cap[i]  = '0;
        slv_sent[i] = 0;
        if (!inst1) begin
          slv_miso[i] = slv_word[i][W-1];
          slv_sent[i] = 1;
        end
      end
      if (!cs_v[i]) begin
        if (inst1 ? trail_v : lead_v) slv_cap[i] = {slv_cap[i][W-2:0], mosi_v[i]};
        if ((inst1 ? lead_v : trail_v) && slv_sent[i] < W) begin
          slv_miso[i] = slv_word[i][W-1-slv_sent[i]];
          slv_sent[i]++;
        end
      end
      prev_sclk[i] = sclk_v[i];
      prev_cs[i]   = cs_v[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_xfer(input bit inst, input logic [W-1:0] tx);
    if (inst) begin start_b = 1'b1; tx_b = tx; end
    else      begin start_a = 1'b1; tx_a = tx; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    // Later tx_data changes must not reach the wire.
    if (inst) tx_b = ~tx; else tx_a = ~tx;
  endtask

  task automatic wait_done(input bit inst, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (inst ? done_b : done_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_xfer(input bit inst, input int mode, input logic [W-1:0] tx,
                         input logic [W-1:0] sw, input int idle);
    logic [W-1:0] exp_rx;
    int lat;
    bit ok;
    slv_word[inst]  = sw;
    miso_mode[inst] = mode;
    exp_rx = (mode == 1) ? tx : (mode == 2) ? {W{1'b1}} : sw;
    repeat (idle) begin @(posedge clk); #1; end
    start_xfer(inst, tx);
    wait_done(inst, lat, ok);
    check("done_seen", ok, 1);
    check("rx_data", inst ? rx_b : rx_a, exp_rx);
    check("mosi_word", slv_cap[inst], tx);
    // SETUP tick 1..3 cycles after accept, then 16 XFER ticks and the HOLD tick 3 apart.
    check("latency_52_55", (lat >= 52 && lat <= 55), 1);
    if (!inst) begin
      check("sclk_rises", rise_cnt, 8);
      check("sclk_period6", per_bad, 0);
      check("sclk_duty", hi_bad, 0);
    end
  endtask

  initial begin
    int dt, sc, lat;
    bit ok;
    logic [W-1:0] r;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    tx_a = '0; tx_b = '0;
    div_stall = 1'b0;
    miso_mode[0] = 1; miso_mode[1] = 1;
    slv_word[0] = '0; slv_word[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk_a", sclk_a, 0);
    check("rst_sclk_b", sclk_b, 1);
    check("rst_cs_n", {cs_a, cs_b}, 2'b11);
    check("rst_mosi", {mosi_a, mosi_b}, 2'b00);
    check("rst_busy_done", {busy_a, done_a, busy_b, done_b}, 4'b0000);
    check("rst_rx_data", {rx_a, rx_b}, 16'h0000);
    rst = 1'b0;

    do_xfer(0, 1, 8'hA5, 8'h00, 2);
    do_xfer(0, 2, 8'h00, 8'h00, 1);
    do_xfer(1, 1, 8'h3C, 8'h00, 3);
    check("cpol1_idle", sclk_b, 1);
    check("cpha1_mosi_on_fall", mosi_bad, 0);

    // Back-to-back: start issued in the done cycle.
    do_xfer(0, 0, 8'h96, 8'h4B, 0);
    do_xfer(0, 0, 8'h69, 8'hD2, 0);

    for (int n = 0; n < 8; n++) begin
      do_xfer(0, 0, W'($urandom), W'($urandom), int'($urandom_range(0, 5)));
      do_xfer(1, 0, W'($urandom), W'($urandom), int'($urandom_range(0, 5)));
    end

    // Second start during a transfer is ignored.
    slv_word[0] = 8'h1E;
    miso_mode[0] = 0;
    dt = done_tot;
    start_xfer(0, 8'hA5);
    repeat (10) begin @(posedge clk); #1; end
    start_a = 1'b1; tx_a = 8'hFF;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(0, lat, ok);
    check("ign_done_seen", ok, 1);
    check("ign_rx", rx_a, 8'h1E);
    check("ign_mosi_word", slv_cap[0], 8'hA5);
    repeat (60) begin @(posedge clk); #1; end
    check("ign_one_done", done_tot - dt, 1);
    check("ign_cs_idle", cs_a, 1);

    // Divider stall mid-transfer, then resume.
    r = W'($urandom);
    miso_mode[0] = 1;
    start_xfer(0, r);
    repeat (10) begin @(posedge clk); #1; end
    div_stall = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    sc = sclk_chg;
    repeat (40) begin @(posedge clk); #1; end
    check("stall_busy_cs", {busy_a, cs_a}, 2'b10);
    check("stall_sclk_static", sclk_chg - sc, 0);
    div_stall = 1'b0;
    wait_done(0, lat, ok);
    check("stall_done_seen", ok, 1);
    check("stall_rx", rx_a, r);

    // Reset mid-XFER.
    miso_mode[0] = 1;
    start_xfer(0, 8'hC3);
    repeat (20) begin @(posedge clk); #1; end
    dt = done_tot;
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {cs_a, sclk_a, busy_a, done_a}, 4'b1000);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (60) begin @(posedge clk); #1; end
    check("rst_no_done", done_tot - dt, 0);
    check("rst_rx_cleared", rx_a, 8'h00);
    do_xfer(0, 1, 8'h5A, 8'h00, 1);

    check("done_one_cycle", done_wide, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_master_shift.md
# spi_master_shift

SPI master shift engine for the SPI path. It takes the divided bit clock from the clock divider (`div_clk`, a register in the `clk` domain) and turns each of its edges into one SCLK half-period. It frames one `DATA_W`-bit full-duplex transfer per `start` request: chip select, MSB-first shifting on MOSI, MISO capture, and a `done` strobe. All logic runs on `clk`; `div_clk` is used only as a data input (edge-detected), never as a clock.

## Interface
- `DATA_W`, 8: bits per transfer, at least 2.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge.

- `clk` in 1: system clock; same clock as the divider.
- `rst` in 1: asynchronous, active-high reset.
- `div_clk` in 1: divider output; each toggle is one half-period tick.
- `start` in 1: transfer request; sampled only in IDLE.
- `tx_data` in DATA_W: word to send; captured in the cycle `start` is accepted.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `rx_data` out DATA_W: last received word; updated in the `done` cycle and held otherwise.
- `sclk` out 1: SPI clock.
- `mosi` out 1: serial data out, MSB first.
- `miso` in 1: serial data in; synchronised externally.
- `cs_n` out 1: active-low chip select.

## Operation
- Tick detection
  - Register `div_q <= div_clk`; reset value 0.
  - `tick = div_clk ^ div_q`.
  - All SCLK, MOSI and state activity below happens only in cycles where `tick` = 1.
- State machine: IDLE, SETUP, XFER, HOLD.
- IDLE
  - `start` = 1 causes the following in the next cycle: state SETUP, `busy` = 1, `cs_n` = 0.
  - The same edge loads `tx_sr <= tx_data`, clears the half-period counter `hp` (width clog2(2·DATA_W)+1), and clears `rx_sr`.
  - `mosi` = `tx_data[DATA_W-1]` when CPHA = 0; it is unchanged when CPHA = 1.
- SETUP
  - The first tick moves to XFER. SCLK does not toggle.
  - This gives at least one half-period of CS-to-SCLK setup.
- XFER
  - Every tick toggles `sclk` and increments `hp`.
  - Tick k (k = hp before increment, 0..2·DATA_W−1): even k is a leading edge, odd k a trailing edge.
  - CPHA = 0:
    - Leading edge: `rx_sr <= {rx_sr[DATA_W-2:0], miso}`.
    - Trailing edge, except k = 2·DATA_W−1: shift `tx_sr` left and drive `mosi` from the new MSB.
  - CPHA = 1:
    - Leading edge: drive `mosi` from `tx_sr` MSB, then shift.
    - Trailing edge: sample `miso` into `rx_sr`.
  - After tick k = 2·DATA_W−1, go to HOLD. `sclk` is back at CPOL.
- HOLD
  - The next tick ends the transfer. On that edge: `cs_n` = 1, `busy` = 0, `done` = 1, `rx_data <= rx_sr`, state IDLE.
  - `done` is cleared on the next clk edge.
- `start` outside IDLE is ignored; there is no queuing.
- `tx_data` changes after acceptance have no effect.
- `rst` (async, any state): state IDLE, `sclk` = CPOL, `cs_n` = 1, `mosi` = 0, `busy` = 0, `done` = 0, `rx_data` = 0, `div_q` = 0, `hp` = 0.
  - A transfer aborted by reset produces no `done`.
- If `div_clk` stops toggling, the FSM stalls in its current state with all outputs held. This is not an error.

## Timing
- Reset values are as listed above. All outputs are registered, with no combinational paths from input to output.
- With the divider's `divide_number` = D (even), a tick occurs every D/2 clk cycles.
- Accept-to-`done` latency is at most 1 + (2·DATA_W + 2)·D/2 cycles.
  - For D = 6 and DATA_W = 8 this is at most 55 cycles.
  - The exact value depends on tick phase at acceptance.
- SCLK period is D clk cycles at 50% duty.
- CS hold after the last SCLK edge is one half-period.
- Back-to-back transfers: a `start` in the `done` cycle is accepted, since the state is already IDLE. Minimum `cs_n`-high time is therefore 1 clk.

## Test plan
- Mode 0, D = 6 divider, `miso` looped to `mosi`, `tx_data` = 8'hA5:
  - `rx_data` = 8'hA5.
  - 8 rising SCLK edges, SCLK period 6 cycles.
  - `cs_n` low throughout; `done` high for exactly 1 cycle.
- `miso` tied 1, `tx_data` = 8'h00:
  - `rx_data` = 8'hFF.
  - `mosi` = 0 on every sampling edge.
- CPOL = 1, CPHA = 1 instance, loopback, `tx_data` = 8'h3C:
  - `sclk` idles 1.
  - `rx_data` = 8'h3C.
  - MOSI changes only on falling SCLK.
- `start` pulsed again 10 cycles into a transfer with `tx_data` = 8'hFF:
  - Ignored; the first word completes unchanged.
  - Exactly one `done`.
- `rst` asserted mid-XFER:
  - Same cycle: `cs_n` = 1, `sclk` = CPOL, `busy` = 0.
  - No `done`.
  - A new transfer after release of 8'h5A loops back correctly.
- `div_clk` held constant after `start`:
  - `busy` = 1, `cs_n` = 0, `sclk` static indefinitely.
  - Resuming toggles completes the transfer normally.
